// File: rtl/urish_simon.sv
// Simon memory game for a TinyTapeout tile: LFSR-generated colour sequence, button input, BCD score on a muxed 7-seg.
// Define SIMON_SOUND_EN to build the per-colour tone generator on uo_out[4]; otherwise the speaker pin is tied low.
module urish_simon #(
  parameter int CLK_HZ  = 50000,
  parameter int MAX_LEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int TICK_DIV = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] LEVEL_MAX = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEVEL_ONE = LW'(1);

  localparam logic [12:0] T_PAUSE = 13'd499;
  localparam logic [12:0] T_ON    = 13'd299;
  localparam logic [12:0] T_GAP   = 13'd99;
  localparam logic [12:0] T_INPUT = 13'd4999;
  localparam logic [12:0] T_LOSE  = 13'd999;
  localparam logic [12:0] T_WIN   = 13'd1999;
  localparam logic [6:0]  T_BLINK = 7'd124;

  localparam logic [2:0] TONE_OFF  = 3'd0;
  localparam logic [2:0] TONE_LOSE = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_PAUSE, S_PLAY_ON, S_PLAY_GAP, S_INPUT, S_LOSE, S_WIN
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic logic [3:0] col_led(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  function automatic logic [2:0] col_tone(input logic [1:0] c);
    return {1'b0, c} + 3'd1;
  endfunction

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:5], uio_in};
  assign uio_oe    = 8'h7F;

  logic [15:0] div_q, div_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, btn_prev_q, btn_prev_d;
  logic        tick, btn_onehot, press;
  logic [1:0]  press_col;

  always_comb begin
    tick       = (div_q == TICK_LAST);
    div_d      = tick ? 16'd0 : div_q + 16'd1;
    lfsr_d     = lfsr_step(lfsr_q);
    btn_s1_d   = ui_in[3:0];
    btn_s2_d   = btn_s1_q;
    btn_prev_d = btn_s2_q;
    // A press needs a rising bit while the whole synchronised vector is one-hot.
    btn_onehot = (btn_s2_q != 4'd0) && ((btn_s2_q & (btn_s2_q - 4'd1)) == 4'd0);
    press      = btn_onehot && ((btn_s2_q & ~btn_prev_q) != 4'd0);
    press_col  = {btn_s2_q[3] | btn_s2_q[2], btn_s2_q[3] | btn_s2_q[1]};
  end

  state_t          state_q, state_d;
  logic [12:0]     tmr_q, tmr_d;
  logic [6:0]      blk_q, blk_d;
  logic [LW-1:0]   idx_q, idx_d, level_q, level_d;
  logic [15:0]     seed_q, seed_d, step_q, step_d, step_nxt, seed_nxt;
  logic [3:0]      led_q, led_d;
  logic [2:0]      tone_q, tone_d;
  logic            held_q, held_d;
  logic [3:0]      tens_q, tens_d, ones_q, ones_d, tens_inc, ones_inc;
  logic            mux_on_q, mux_on_d, dig_sel_q, dig_sel_d;

  always_comb begin
    if (ones_q == 4'd9) begin
      ones_inc = 4'd0;
      tens_inc = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
    end else begin
      ones_inc = ones_q + 4'd1;
      tens_inc = tens_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    blk_d    = blk_q;
    idx_d    = idx_q;
    level_d  = level_q;
    seed_d   = seed_q;
    step_d   = step_q;
    led_d    = led_q;
    tone_d   = tone_q;
    held_d   = held_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    step_nxt = lfsr_step(step_q);
    seed_nxt = lfsr_step(seed_q);
    mux_on_d  = 1'b1;
    dig_sel_d = tick ? ~dig_sel_q : dig_sel_q;

    case (state_q)
      S_IDLE: begin
        led_d  = 4'd0;
        tone_d = TONE_OFF;
        if (press) begin
          seed_d  = (lfsr_q == 16'd0) ? 16'd1 : lfsr_q;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          level_d = LEVEL_ONE;
          idx_d   = '0;
          tmr_d   = 13'd0;
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (tick) begin
          if (tmr_q == T_PAUSE) begin
            tmr_d   = 13'd0;
            idx_d   = '0;
            step_d  = seed_nxt;
            led_d   = col_led(seed_nxt[1:0]);
            tone_d  = col_tone(seed_nxt[1:0]);
            state_d = S_PLAY_ON;
          end else begin
            tmr_d = tmr_q + 13'd1;
          end
        end
      end
      S_PLAY_ON: begin
        if (tick) begin
          if (tmr_q == T_ON) begin
            tmr_d   = 13'd0;
            led_d   = 4'd0;
            tone_d  = TONE_OFF;
            state_d = S_PLAY_GAP;
          end else begin
            tmr_d = tmr_q + 13'd1;
          end
        end
      end
      S_PLAY_GAP: begin
        if (tick) begin
          if (tmr_q == T_GAP) begin
            tmr_d = 13'd0;
            if (idx_q == level_q - LEVEL_ONE) begin
              // Rewind the step generator so input is checked against the same sequence.
              idx_d   = '0;
              step_d  = seed_q;
              held_d  = 1'b0;
              state_d = S_INPUT;
            end else begin
              idx_d   = idx_q + LEVEL_ONE;
              step_d  = step_nxt;
              led_d   = col_led(step_nxt[1:0]);
              tone_d  = col_tone(step_nxt[1:0]);
              state_d = S_PLAY_ON;
            end
          end else begin
            tmr_d = tmr_q + 13'd1;
          end
        end
      end
      S_INPUT: begin
        if (held_q) begin
          // step_q already points at the held colour; wait for that button to drop.
          if (!btn_s2_q[step_q[1:0]]) begin
            held_d = 1'b0;
            led_d  = 4'd0;
            tone_d = TONE_OFF;
            tmr_d  = 13'd0;
            if (idx_q == level_q - LEVEL_ONE) begin
              ones_d = ones_inc;
              tens_d = tens_inc;
              idx_d  = '0;
              if (level_q == LEVEL_MAX) begin
                led_d   = 4'hF;
                blk_d   = 7'd0;
                state_d = S_WIN;
              end else begin
                level_d = level_q + LEVEL_ONE;
                state_d = S_PAUSE;
              end
            end else begin
              idx_d = idx_q + LEVEL_ONE;
            end
          end
        end else if (press) begin
          tmr_d = 13'd0;
          if (press_col == step_nxt[1:0]) begin
            held_d = 1'b1;
            step_d = step_nxt;
            led_d  = col_led(press_col);
            tone_d = col_tone(press_col);
          end else begin
            led_d   = 4'hF;
            tone_d  = TONE_LOSE;
            state_d = S_LOSE;
          end
        end else if (tick) begin
          if (tmr_q == T_INPUT) begin
            tmr_d   = 13'd0;
            led_d   = 4'hF;
            tone_d  = TONE_LOSE;
            state_d = S_LOSE;
          end else begin
            tmr_d = tmr_q + 13'd1;
          end
        end
      end
      S_LOSE: begin
        if (tick) begin
          if (tmr_q == T_LOSE) begin
            tmr_d   = 13'd0;
            led_d   = 4'd0;
            tone_d  = TONE_OFF;
            state_d = S_IDLE;
          end else begin
            tmr_d = tmr_q + 13'd1;
          end
        end
      end
      S_WIN: begin
        tone_d = TONE_OFF;
        if (tick) begin
          if (tmr_q == T_WIN) begin
            tmr_d   = 13'd0;
            led_d   = 4'd0;
            state_d = S_IDLE;
          end else begin
            tmr_d = tmr_q + 13'd1;
            // 125 ms half-period gives the 4 Hz blink.
            if (blk_q == T_BLINK) begin
              blk_d = 7'd0;
              led_d = ~led_q;
            end else begin
              blk_d = blk_q + 7'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= 16'd0;
      lfsr_q     <= 16'hACE1;
      btn_s1_q   <= 4'd0;
      btn_s2_q   <= 4'd0;
      btn_prev_q <= 4'd0;
      state_q    <= S_IDLE;
      tmr_q      <= 13'd0;
      blk_q      <= 7'd0;
      idx_q      <= '0;
      level_q    <= '0;
      seed_q     <= 16'd1;
      step_q     <= 16'd1;
      led_q      <= 4'd0;
      tone_q     <= TONE_OFF;
      held_q     <= 1'b0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      mux_on_q   <= 1'b0;
      dig_sel_q  <= 1'b0;
    end else begin
      div_q      <= div_d;
      lfsr_q     <= lfsr_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      btn_prev_q <= btn_prev_d;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      blk_q      <= blk_d;
      idx_q      <= idx_d;
      level_q    <= level_d;
      seed_q     <= seed_d;
      step_q     <= step_d;
      led_q      <= led_d;
      tone_q     <= tone_d;
      held_q     <= held_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      mux_on_q   <= mux_on_d;
      dig_sel_q  <= dig_sel_d;
    end
  end

  logic       spk;
  logic [3:0] digit;
  logic [6:0] seg_pat;

`ifdef SIMON_SOUND_EN
  localparam logic [15:0] HP_C0   = 16'(((CLK_HZ / 392) > 1 ? CLK_HZ / 392 : 1) - 1);
  localparam logic [15:0] HP_C1   = 16'(((CLK_HZ / 524) > 1 ? CLK_HZ / 524 : 1) - 1);
  localparam logic [15:0] HP_C2   = 16'(((CLK_HZ / 660) > 1 ? CLK_HZ / 660 : 1) - 1);
  localparam logic [15:0] HP_C3   = 16'(((CLK_HZ / 784) > 1 ? CLK_HZ / 784 : 1) - 1);
  localparam logic [15:0] HP_LOSE = 16'(((CLK_HZ / 220) > 1 ? CLK_HZ / 220 : 1) - 1);

  logic [15:0] tcnt_q, tcnt_d, hp_last;
  logic        spk_q, spk_d;

  always_comb begin
    case (tone_q)
      3'd1:    hp_last = HP_C0;
      3'd2:    hp_last = HP_C1;
      3'd3:    hp_last = HP_C2;
      3'd4:    hp_last = HP_C3;
      default: hp_last = HP_LOSE;
    endcase
    tcnt_d = tcnt_q + 16'd1;
    spk_d  = spk_q;
    if (tone_q == TONE_OFF) begin
      tcnt_d = 16'd0;
      spk_d  = 1'b0;
    end else if (tcnt_q >= hp_last) begin
      tcnt_d = 16'd0;
      spk_d  = ~spk_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= 16'd0;
      spk_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      spk_q  <= spk_d;
    end
  end

  assign spk = spk_q;
`else
  logic unused_tone;
  assign unused_tone = ^tone_q;
  assign spk         = 1'b0;
`endif

  always_comb begin
    digit = (mux_on_q && dig_sel_q) ? tens_q : ones_q;
    case (digit)
      4'd0:    seg_pat = 7'h3F;
      4'd1:    seg_pat = 7'h06;
      4'd2:    seg_pat = 7'h5B;
      4'd3:    seg_pat = 7'h4F;
      4'd4:    seg_pat = 7'h66;
      4'd5:    seg_pat = 7'h6D;
      4'd6:    seg_pat = 7'h7D;
      4'd7:    seg_pat = 7'h07;
      4'd8:    seg_pat = 7'h7F;
      4'd9:    seg_pat = 7'h6F;
      default: seg_pat = 7'h00;
    endcase
  end

  assign uio_out = {1'b0, seg_pat ^ {7{ui_in[4]}}};
  assign uo_out  = {1'b0, mux_on_q & ~dig_sel_q, mux_on_q & dig_sel_q, spk, led_q};
endmodule

// File: tb/tb_urish_simon.sv
// Scoreboard bench for urish_simon: stimulus queues expected LED segments, a monitor pops and compares them.
// Runs with CLK_HZ=1000 (1 ms per cycle) and MAX_LEN=3 so a full win fits in a short run.
module tb_urish_simon;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uio_in = 8'd0;
  logic [7:0] uo_out, uio_out, uio_oe;

  always #5 clk = ~clk;

  urish_simon #(.CLK_HZ(1000), .MAX_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  typedef struct {
    logic [3:0] led;
    int         len;
  } seg_t;

  seg_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc;
  int   col[0:7];
  int   spk_toggles = 0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  default: return 7'h6F;
    endcase
  endfunction

  // Monitor: splits the LED output into lit segments and compares each against the scoreboard.
  initial begin
    logic [3:0] cur_led;
    int         cur_len;
    logic       spk_prev;
    logic       bad;
    seg_t       e;
    cur_led = 4'd0; cur_len = 0; spk_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_led = 4'd0; cur_len = 0; spk_prev = 1'b0;
      end else begin
        checks++;
        bad = (uo_out[5] && uo_out[6]) || uo_out[7] || uio_out[7] || (uio_oe != 8'h7F);
`ifndef SIMON_SOUND_EN
        bad = bad || uo_out[4];
`endif
        if (bad) begin
          errors++;
          $display("FAIL static_pins: uo_out=%h uio_out=%h uio_oe=%h", uo_out, uio_out, uio_oe);
        end
        if (uo_out[4] != spk_prev) spk_toggles++;
        spk_prev = uo_out[4];
        if (uo_out[3:0] != cur_led) begin
          if (cur_led != 4'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_segment: got led=%b len=%0d, required none", cur_led, cur_len);
            end else begin
              e = exp_q.pop_front();
              if (e.led != cur_led || e.len != cur_len) begin
                errors++;
                $display("FAIL led_segment: got led=%b len=%0d, required led=%b len=%0d",
                         cur_led, cur_len, e.led, e.len);
              end else begin
                $display("segment led=%b len=%0d ok", cur_led, cur_len);
              end
            end
          end
          cur_led = uo_out[3:0];
          cur_len = 1;
        end else begin
          cur_len++;
        end
      end
    end
  end

  task automatic push(input logic [3:0] l, input int n);
    seg_t e;
    e.led = l; e.len = n;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int limit, input string what);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d segments still pending after %0d cycles, required 0", what, exp_q.size(), limit);
      exp_q.delete();
    end
  endtask

  task automatic do_press(input logic [3:0] b, input int hold);
    @(negedge clk);
    ui_in[3:0] = b;
    repeat (hold) @(negedge clk);
    ui_in[3:0] = 4'd0;
  endtask

  // Seed = free LFSR after (press cycle + 2 synchroniser stages) steps from reset.
  task automatic start_game();
    logic [15:0] s;
    logic [3:0]  b;
    int          p;
    b = 4'b0001 << $urandom_range(0, 3);
    repeat ($urandom_range(3, 40)) @(negedge clk);
    p = cyc;
    ui_in[3:0] = b;
    s = 16'hACE1;
    for (int k = 0; k < p + 2; k++) s = lfsr_next(s);
    if (s == 16'd0) s = 16'd1;
    for (int i = 0; i < 8; i++) begin
      s = lfsr_next(s);
      col[i] = int'(s[1:0]);
    end
    $display("start game btn=%b at cycle %0d, colours %0d %0d %0d", b, p, col[0], col[1], col[2]);
    repeat (10) @(negedge clk);
    ui_in[3:0] = 4'd0;
  endtask

  task automatic play_level(input int lvl);
    for (int i = 0; i < lvl; i++) push(4'b0001 << col[i], 300);
    wait_drain(500 + 400 * lvl + 100, "playback");
    repeat (120 + $urandom_range(0, 30)) @(negedge clk);
  endtask

  task automatic repeat_seq(input int lvl, input int wrong_at);
    int hold;
    int c;
    for (int i = 0; i < lvl; i++) begin
      hold = $urandom_range(5, 40);
      if (i == wrong_at) begin
        c = (col[i] + $urandom_range(1, 3)) % 4;
        push(4'hF, 1000);
        $display("press wrong colour %0d (expected %0d) hold %0d", c, col[i], hold);
        do_press(4'b0001 << c, hold);
        return;
      end
      push(4'b0001 << col[i], hold);
      $display("press colour %0d hold %0d", col[i], hold);
      do_press(4'b0001 << col[i], hold);
      repeat ($urandom_range(5, 20)) @(negedge clk);
    end
  endtask

  task automatic check_score(input int s, input logic inv);
    logic [6:0] mask;
    logic       saw_t, saw_o;
    mask = inv ? 7'h7F : 7'h00;
    ui_in[4] = inv;
    saw_t = 1'b0; saw_o = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (uo_out[5] && !uo_out[6]) begin
        saw_t = 1'b1;
        if (uio_out[6:0] != (pat(s / 10) ^ mask)) begin
          errors++;
          $display("FAIL score_tens: seg=%h, required %h", uio_out[6:0], pat(s / 10) ^ mask);
        end
      end else if (uo_out[6] && !uo_out[5]) begin
        saw_o = 1'b1;
        if (uio_out[6:0] != (pat(s % 10) ^ mask)) begin
          errors++;
          $display("FAIL score_ones: seg=%h, required %h", uio_out[6:0], pat(s % 10) ^ mask);
        end
      end else begin
        errors++;
        $display("FAIL digit_select: dig1=%b dig2=%b, required exactly one", uo_out[5], uo_out[6]);
      end
    end
    checks++;
    if (!(saw_t && saw_o)) begin
      errors++;
      $display("FAIL mux_alternate: saw tens=%b ones=%b, required both", saw_t, saw_o);
    end
    $display("score check %02d seginv=%b done", s, inv);
    ui_in[4] = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    checks++;
    if (uo_out != 8'd0 || uio_oe != 8'h7F || uio_out[6:0] != 7'h3F) begin
      errors++;
      $display("FAIL reset_outputs: uo_out=%h uio_oe=%h seg=%h, required 00 7f 3f", uo_out, uio_oe, uio_out[6:0]);
    end
    ui_in[4] = 1'b1;
    #1;
    checks++;
    if (uio_out[6:0] != 7'h40) begin
      errors++;
      $display("FAIL reset_seginv: seg=%h, required 40", uio_out[6:0]);
    end
    ui_in[4] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_score(0, 1'b0);

    // Game 1: play all levels correctly and win
    start_game();
    for (int lvl = 1; lvl <= 3; lvl++) begin
      play_level(lvl);
      repeat_seq(lvl, -1);
    end
    for (int i = 0; i < 8; i++) push(4'hF, 125);
    wait_drain(2500, "win");
    repeat (200) @(negedge clk);
    check_score(3, 1'b0);
    check_score(3, 1'b1);

    // Game 2: clear level 1, then a wrong press in level 2
    start_game();
    play_level(1);
    repeat_seq(1, -1);
    play_level(2);
    spk_toggles = 0;
    repeat_seq(2, $urandom_range(0, 1));
    wait_drain(1300, "lose");
`ifdef SIMON_SOUND_EN
    checks++;
    if (spk_toggles < 240 || spk_toggles > 260) begin
      errors++;
      $display("FAIL lose_tone: %0d speaker toggles, required about 250 (110 Hz)", spk_toggles);
    end
`endif
    repeat (20) @(negedge clk);
    check_score(1, 1'b0);

    // Game 3: a two-button press is ignored, then the input timeout loses
    start_game();
    play_level(1);
    $display("press two buttons 0011 together");
    do_press(4'b0011, 30);
    repeat (10) @(negedge clk);
    push(4'hF, 1000);
    wait_drain(6200, "timeout_lose");
    repeat (20) @(negedge clk);
    check_score(0, 1'b0);

    // Game 4: reset in the middle of playback
    start_game();
    n = 0;
    while (uo_out[3:0] == 4'd0 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (uo_out[3:0] == 4'd0) begin
      errors++;
      $display("FAIL play_start: led=%b after %0d cycles, required a lit led", uo_out[3:0], n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (uo_out != 8'd0 || uio_oe != 8'h7F) begin
      errors++;
      $display("FAIL async_reset: uo_out=%h uio_oe=%h, required 00 7f", uo_out, uio_oe);
    end
    $display("reset asserted during playback");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_score(0, 1'b0);
    repeat (600) @(negedge clk);
    checks++;
    if (uo_out[3:0] != 4'd0) begin
      errors++;
      $display("FAIL idle_after_reset: led=%b, required 0000", uo_out[3:0]);
    end
    wait_drain(1, "final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
